// File: rtl/idiv_seq.sv
// Sequential unsigned radix-2 restoring divider: 2*SIZE-bit dividend / SIZE-bit divisor.
// One quotient bit per clock; start/done handshake, a zero divisor completes in one cycle.
module idiv_seq #(
  parameter int SIZE = 4
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                iStart,
  input  logic [2*SIZE-1:0]   iDividend,
  input  logic [SIZE-1:0]     iDivisor,
  output logic                oBusy,
  output logic                oDone,
  output logic [2*SIZE-1:0]   oQuotient,
  output logic [SIZE-1:0]     oRemainder,
  output logic                oDivByZero
);

  localparam int W  = 2 * SIZE;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nx;
  logic [W-1:0]    dvd, dvd_nx;
  logic [SIZE-1:0] dsr, dsr_nx;
  logic [SIZE:0]   rem, rem_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [W-1:0]    quo_q, quo_nx;
  logic [SIZE-1:0] rmd_q, rmd_nx;
  logic            dbz_q, dbz_nx;

  // One extra bit on the trial difference so its MSB is the borrow.
  logic [SIZE:0]   shifted;
  logic [SIZE+1:0] trial;
  logic            neg;
  logic [SIZE:0]   step_rem;
  logic [W-1:0]    step_quo;

  assign shifted  = {rem[SIZE-1:0], dvd[W-1]};
  assign trial    = {1'b0, shifted} - {2'b00, dsr};
  assign neg      = trial[SIZE+1];
  assign step_rem = neg ? shifted : trial[SIZE:0];
  assign step_quo = {dvd[W-2:0], ~neg};

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state <= IDLE;
      dvd   <= '0;
      dsr   <= '0;
      rem   <= '0;
      cnt   <= '0;
      quo_q <= '0;
      rmd_q <= '0;
      dbz_q <= 1'b0;
    end else begin
      state <= state_nx;
      dvd   <= dvd_nx;
      dsr   <= dsr_nx;
      rem   <= rem_nx;
      cnt   <= cnt_nx;
      quo_q <= quo_nx;
      rmd_q <= rmd_nx;
      dbz_q <= dbz_nx;
    end
  end

  always_comb begin
    state_nx = state;
    dvd_nx   = dvd;
    dsr_nx   = dsr;
    rem_nx   = rem;
    cnt_nx   = cnt;
    quo_nx   = quo_q;
    rmd_nx   = rmd_q;
    dbz_nx   = dbz_q;
    case (state)
      IDLE, DONE: begin
        if (iStart) begin
          if (iDivisor == '0) begin
            state_nx = DONE;
            quo_nx   = '1;
            rmd_nx   = iDividend[SIZE-1:0];
            dbz_nx   = 1'b1;
          end else begin
            state_nx = RUN;
            dvd_nx   = iDividend;
            dsr_nx   = iDivisor;
            rem_nx   = '0;
            cnt_nx   = CW'(W);
          end
        end else begin
          state_nx = IDLE;
        end
      end
      RUN: begin
        dvd_nx = step_quo;
        rem_nx = step_rem;
        cnt_nx = cnt - CW'(1);
        // Results are published only on the final step so they hold through RUN.
        if (cnt == CW'(1)) begin
          state_nx = DONE;
          quo_nx   = step_quo;
          rmd_nx   = step_rem[SIZE-1:0];
          dbz_nx   = 1'b0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign oBusy      = (state == RUN);
  assign oDone      = (state == DONE);
  assign oQuotient  = quo_q;
  assign oRemainder = rmd_q;
  assign oDivByZero = dbz_q;

endmodule
